// File: rtl/s15611_pkg.sv
// Shared constants and state encodings for the s15611 line packer.
package s15611_pkg;

  localparam int unsigned DEF_PIX_W = 12;
  localparam int unsigned IDX_W     = 10;

  typedef enum logic [1:0] {
    BUF_FREE,
    BUF_FILLING,
    BUF_FULL,
    BUF_DRAINING
  } buf_state_t;

  typedef enum logic {
    WR_IDLE,
    WR_FILL
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RUN
  } rd_state_t;

endpackage

// File: rtl/s15611_line_ram.sv
// Simple dual-port line RAM: one write port, one registered read port.
// The address MSB selects the ping-pong buffer; storage is not reset.
module s15611_line_ram
  import s15611_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_PIX_W,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/s15611_line_packer.sv
// Assembles driver pixel lines into a ping-pong RAM and streams each complete
// line, dark-offset corrected, as an AXI4-Stream packet.
module s15611_line_packer
  import s15611_pkg::*;
#(
  parameter int unsigned NUMBER_OF_PIXEL = 128,
  parameter int unsigned PIX_W           = DEF_PIX_W,
  parameter int unsigned TDATA_W         = 16
) (
  input  logic               master_clock,
  input  logic               resetn,
  input  logic [PIX_W-1:0]   pix_data,
  input  logic [IDX_W-1:0]   pix_index,
  input  logic               pix_valid,
  input  logic               enable,
  input  logic [PIX_W-1:0]   dark_offset,
  output logic [TDATA_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser,
  output logic [15:0]        line_count,
  output logic [15:0]        drop_count
);

  localparam int unsigned AW_I = $clog2(NUMBER_OF_PIXEL);
  localparam int unsigned AW   = AW_I + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBER_OF_PIXEL - 1);

  wr_state_t         wr_state_q, wr_state_d;
  logic              wr_buf_q, wr_buf_d;
  logic [IDX_W-1:0]  wr_exp_q, wr_exp_d;
  buf_state_t        buf_q [2];
  buf_state_t        buf_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  rd_state_t         rd_state_q, rd_state_d;
  logic              rd_buf_q, rd_buf_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [PIX_W-1:0]  offset_q, offset_d;
  logic              rvalid_q, rvalid_d, rlast_q, rlast_d, ruser_q, ruser_d, rbuf_q, rbuf_d;
  logic [1:0]        out_cnt_q, out_cnt_d;
  logic [TDATA_W-1:0] e0_data_q, e0_data_d, e1_data_q, e1_data_d;
  logic              e0_last_q, e0_last_d, e0_user_q, e0_user_d, e0_buf_q, e0_buf_d;
  logic              e1_last_q, e1_last_d, e1_user_q, e1_user_d, e1_buf_q, e1_buf_d;
  logic [15:0]       line_count_q, line_count_d, drop_count_q, drop_count_d;

  logic              wr_claim, claim_buf, wr_done, wr_abort, drop_inc;
  logic              rd_start, rd_sel, any_full, can_issue, pop, push, release_buf;
  logic [2:0]        occ;
  logic              ram_we, ram_re;
  logic [AW-1:0]     ram_waddr, ram_raddr;
  logic [PIX_W-1:0]  ram_rdata, corr;
  logic [TDATA_W-1:0] push_data;

  s15611_line_ram #(
    .DATA_W (PIX_W),
    .ADDR_W (AW)
  ) u_ram (
    .clk   (master_clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (pix_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Write side: claim a free buffer on index 0, then demand strictly in-order indices.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_buf_d   = wr_buf_q;
    wr_exp_d   = wr_exp_q;
    wr_claim   = 1'b0;
    claim_buf  = 1'b0;
    wr_done    = 1'b0;
    wr_abort   = 1'b0;
    drop_inc   = 1'b0;
    ram_we     = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (pix_valid && enable && pix_index == '0) begin
          if (buf_q[0] == BUF_FREE || buf_q[1] == BUF_FREE) begin
            wr_claim   = 1'b1;
            claim_buf  = (buf_q[0] != BUF_FREE);
            wr_buf_d   = claim_buf;
            ram_we     = 1'b1;
            wr_exp_d   = IDX_W'(1);
            wr_state_d = WR_FILL;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      default: begin
        if (!enable) begin
          wr_abort   = 1'b1;
          wr_state_d = WR_IDLE;
        end else if (pix_valid) begin
          if (pix_index == '0) begin
            drop_inc = 1'b1;
            ram_we   = 1'b1;
            wr_exp_d = IDX_W'(1);
          end else if (pix_index == wr_exp_q) begin
            ram_we = 1'b1;
            if (pix_index == LAST_IDX) begin
              wr_done    = 1'b1;
              wr_state_d = WR_IDLE;
              if (buf_q[~wr_buf_q] != BUF_FULL) rd_ptr_d = wr_buf_q;
            end else begin
              wr_exp_d = wr_exp_q + IDX_W'(1);
            end
          end else begin
            drop_inc   = 1'b1;
            wr_abort   = 1'b1;
            wr_state_d = WR_IDLE;
          end
        end
      end
    endcase
    ram_waddr = {wr_buf_d, pix_index[AW_I-1:0]};
  end

  assign pop       = (out_cnt_q != 2'd0) && m_axis_tready;
  assign push      = rvalid_q;
  // Reads are only issued when the skid stage is guaranteed room for the result.
  assign occ       = {1'b0, out_cnt_q} + {2'b00, rvalid_q} - {2'b00, pop};
  assign can_issue = (occ < 3'd2);
  assign any_full  = (buf_q[0] == BUF_FULL) || (buf_q[1] == BUF_FULL);
  assign rd_sel    = (buf_q[0] == BUF_FULL && buf_q[1] == BUF_FULL) ? rd_ptr_q
                                                                    : (buf_q[1] == BUF_FULL);

  always_comb begin
    rd_state_d = rd_state_q;
    rd_buf_d   = rd_buf_q;
    rd_idx_d   = rd_idx_q;
    offset_d   = offset_q;
    rd_start   = 1'b0;
    ram_re     = 1'b0;
    ram_raddr  = {rd_buf_q, rd_idx_q[AW_I-1:0]};
    rvalid_d   = 1'b0;
    rlast_d    = 1'b0;
    ruser_d    = 1'b0;
    rbuf_d     = rd_buf_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (any_full && can_issue) begin
          rd_start   = 1'b1;
          rd_buf_d   = rd_sel;
          offset_d   = dark_offset;
          ram_re     = 1'b1;
          ram_raddr  = {rd_sel, {AW_I{1'b0}}};
          rvalid_d   = 1'b1;
          ruser_d    = 1'b1;
          rbuf_d     = rd_sel;
          rd_idx_d   = IDX_W'(1);
          rd_state_d = RD_RUN;
        end
      end
      default: begin
        if (can_issue) begin
          ram_re   = 1'b1;
          rvalid_d = 1'b1;
          rlast_d  = (rd_idx_q == LAST_IDX);
          if (rd_idx_q == LAST_IDX) rd_state_d = RD_IDLE;
          else rd_idx_d = rd_idx_q + IDX_W'(1);
        end
      end
    endcase
  end

  assign corr      = (ram_rdata >= offset_q) ? ram_rdata - offset_q : '0;
  assign push_data = TDATA_W'(corr);

  always_comb begin
    e0_data_d = e0_data_q; e0_last_d = e0_last_q; e0_user_d = e0_user_q; e0_buf_d = e0_buf_q;
    e1_data_d = e1_data_q; e1_last_d = e1_last_q; e1_user_d = e1_user_q; e1_buf_d = e1_buf_q;
    out_cnt_d = out_cnt_q + {1'b0, push} - {1'b0, pop};
    if (pop && out_cnt_q == 2'd2) begin
      e0_data_d = e1_data_q; e0_last_d = e1_last_q; e0_user_d = e1_user_q; e0_buf_d = e1_buf_q;
    end
    if (push) begin
      if (out_cnt_q == 2'd0 || (pop && out_cnt_q == 2'd1)) begin
        e0_data_d = push_data; e0_last_d = rlast_q; e0_user_d = ruser_q; e0_buf_d = rbuf_q;
      end else begin
        e1_data_d = push_data; e1_last_d = rlast_q; e1_user_d = ruser_q; e1_buf_d = rbuf_q;
      end
    end
    release_buf  = pop && e0_last_q;
    line_count_d = line_count_q + {15'd0, release_buf};
    drop_count_d = (drop_inc && drop_count_q != '1) ? drop_count_q + 16'd1 : drop_count_q;
  end

  always_comb begin
    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    if (wr_claim)    buf_d[claim_buf] = BUF_FILLING;
    if (wr_done)     buf_d[wr_buf_q]  = BUF_FULL;
    if (wr_abort)    buf_d[wr_buf_q]  = BUF_FREE;
    if (rd_start)    buf_d[rd_sel]    = BUF_DRAINING;
    if (release_buf) buf_d[e0_buf_q]  = BUF_FREE;
  end

  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      wr_state_q <= WR_IDLE;   wr_buf_q <= 1'b0;  wr_exp_q <= '0;
      buf_q[0]   <= BUF_FREE;  buf_q[1] <= BUF_FREE;
      rd_ptr_q   <= 1'b0;      rd_state_q <= RD_IDLE;
      rd_buf_q   <= 1'b0;      rd_idx_q <= '0;    offset_q <= '0;
      rvalid_q   <= 1'b0;      rlast_q <= 1'b0;   ruser_q <= 1'b0;  rbuf_q <= 1'b0;
      out_cnt_q  <= '0;
      e0_data_q  <= '0; e0_last_q <= 1'b0; e0_user_q <= 1'b0; e0_buf_q <= 1'b0;
      e1_data_q  <= '0; e1_last_q <= 1'b0; e1_user_q <= 1'b0; e1_buf_q <= 1'b0;
      line_count_q <= '0;      drop_count_q <= '0;
    end else begin
      wr_state_q <= wr_state_d; wr_buf_q <= wr_buf_d; wr_exp_q <= wr_exp_d;
      buf_q[0]   <= buf_d[0];   buf_q[1] <= buf_d[1];
      rd_ptr_q   <= rd_ptr_d;   rd_state_q <= rd_state_d;
      rd_buf_q   <= rd_buf_d;   rd_idx_q <= rd_idx_d; offset_q <= offset_d;
      rvalid_q   <= rvalid_d;   rlast_q <= rlast_d; ruser_q <= ruser_d; rbuf_q <= rbuf_d;
      out_cnt_q  <= out_cnt_d;
      e0_data_q  <= e0_data_d; e0_last_q <= e0_last_d; e0_user_q <= e0_user_d; e0_buf_q <= e0_buf_d;
      e1_data_q  <= e1_data_d; e1_last_q <= e1_last_d; e1_user_q <= e1_user_d; e1_buf_q <= e1_buf_d;
      line_count_q <= line_count_d; drop_count_q <= drop_count_d;
    end
  end

  assign m_axis_tvalid = (out_cnt_q != 2'd0);
  assign m_axis_tdata  = e0_data_q;
  assign m_axis_tlast  = e0_last_q;
  assign m_axis_tuser  = e0_user_q;
  assign line_count    = line_count_q;
  assign drop_count    = drop_count_q;

endmodule
